// File: rtl/host_arbiter_if.sv
// Host-side signals of the dual-host arbiter: raw chip selects in, host-mux select and grant out.
interface host_arbiter_if;
  logic mh_cs_n;
  logic sh_cs_n;
  logic host_select;
  logic grant_valid;

  modport master (output mh_cs_n, output sh_cs_n, input host_select, input grant_valid);
  modport slave  (input mh_cs_n, input sh_cs_n, output host_select, output grant_valid);
endinterface

// File: rtl/host_arbiter.sv
// Dual-host SPI flash ownership arbiter: grants the shared host path on frame boundaries,
// with round-robin tie-break, post-release guard interval and a saturating conflict counter.
module host_arbiter #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  host_arbiter_if.slave    bus,
  input  logic             arb_enable,
  input  logic             fixed_select,
  input  logic             conflict_clear,
  output logic             blocked_event,
  output logic [7:0]       conflict_count,
  output logic [1:0]       arb_state
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] BUSY  = 2'b01;
  localparam logic [1:0] GUARD = 2'b10;
  localparam int unsigned GW = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_m, sync_s;
  logic                   req_m, req_s, req_m_q, req_s_q, rise_m, rise_s;
  logic                   stale_m, stale_s, stale_m_d, stale_s_d;
  logic                   elig_m, elig_s, winner, owner_req, blocked;
  logic                   last_grant, host_sel_q, grant_q;
  logic [1:0]             state;
  logic [GW-1:0]          guard_cnt;

  assign req_m           = ~sync_m[SYNC_STAGES-1];
  assign req_s           = ~sync_s[SYNC_STAGES-1];
  assign bus.host_select = host_sel_q;
  assign bus.grant_valid = grant_q;
  assign arb_state       = state;

  always_comb begin
    rise_m    = req_m & ~req_m_q;
    rise_s    = req_s & ~req_s_q;
    elig_m    = req_m & ~stale_m & (arb_enable | ~fixed_select);
    elig_s    = req_s & ~stale_s & (arb_enable | fixed_select);
    winner    = (elig_m & elig_s) ? ~last_grant : elig_s;
    owner_req = host_sel_q ? req_s : req_m;
    blocked   = (state != IDLE) & (host_sel_q ? rise_m : rise_s);

    // A request that starts while the path is taken by someone else must be
    // withdrawn and re-issued before it can win, so mid-frame hosts never get the bus.
    stale_m_d = stale_m;
    if (rise_m && (state != IDLE) && !((state == BUSY) && !host_sel_q)) stale_m_d = 1'b1;
    else if (!req_m)                                                   stale_m_d = 1'b0;
    stale_s_d = stale_s;
    if (rise_s && (state != IDLE) && !((state == BUSY) && host_sel_q)) stale_s_d = 1'b1;
    else if (!req_s)                                                  stale_s_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_m         <= '1;
      sync_s         <= '1;
      req_m_q        <= 1'b0;
      req_s_q        <= 1'b0;
      stale_m        <= 1'b0;
      stale_s        <= 1'b0;
      last_grant     <= 1'b1;
      host_sel_q     <= 1'b0;
      grant_q        <= 1'b0;
      blocked_event  <= 1'b0;
      conflict_count <= '0;
      state          <= IDLE;
      guard_cnt      <= '0;
    end else begin
      sync_m        <= {sync_m[SYNC_STAGES-2:0], bus.mh_cs_n};
      sync_s        <= {sync_s[SYNC_STAGES-2:0], bus.sh_cs_n};
      req_m_q       <= req_m;
      req_s_q       <= req_s;
      stale_m       <= stale_m_d;
      stale_s       <= stale_s_d;
      blocked_event <= blocked;

      if (conflict_clear)                      conflict_count <= '0;
      else if (blocked && conflict_count != '1) conflict_count <= conflict_count + 8'd1;

      case (state)
        IDLE: begin
          if (elig_m || elig_s) begin
            host_sel_q <= winner;
            last_grant <= winner;
            grant_q    <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_req) begin
            grant_q <= 1'b0;
            if (GUARD_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              state     <= GUARD;
              guard_cnt <= GW'(GUARD_CYCLES);
            end
          end
        end
        GUARD: begin
          // Leaving on count 1 makes GUARD last exactly GUARD_CYCLES cycles.
          if (guard_cnt <= GW'(1)) begin
            state     <= IDLE;
            guard_cnt <= '0;
          end else begin
            guard_cnt <= guard_cnt - GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
